// File: rtl/core_s1_fetch.sv
// core_s1_fetch: stage-s1 instruction fetch initiator.
// Holds the fetch PC, issues word-aligned requests to the MMU with at most
// one outstanding, and buffers one returned instruction (instr, pc, fault)
// for s2 behind a valid/ready handshake. Redirects retarget fetch and flush
// the buffer; an access fault halts fetch until the next redirect.

module core_s1_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mmu_req_valid,
  output logic [31:0] mmu_req_addr,
  input  logic        mmu_req_ready,
  input  logic        mmu_rsp_valid,
  input  logic [31:0] mmu_rsp_instr,
  input  logic        mmu_rsp_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        s2_valid,
  input  logic        s2_ready,
  output logic [31:0] s2_instr,
  output logic [31:0] s2_pc,
  output logic        s2_fault
);

  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_FETCH   = 3'd1;
  localparam logic [2:0]  ST_WAIT    = 3'd2;
  localparam logic [2:0]  ST_DISCARD = 3'd3;
  localparam logic [2:0]  ST_HALT    = 3'd4;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] inflight_pc_r;

  logic        buf_valid_r;
  logic [31:0] buf_instr_r;
  logic [31:0] buf_pc_r;
  logic        buf_fault_r;

  logic        req_valid_s;
  logic        req_fire_s;
  logic        s2_accept_s;
  logic        capture_s;
  logic        rsp_window_s;
  logic [31:0] redirect_pc_s;

  // Request/handshake qualifiers derived from the current state and inputs.
  always_comb begin
    redirect_pc_s = redirect_addr & WORD_MASK;
    // A request may go out while the buffer is empty or draining this cycle.
    if (state_r == ST_FETCH) begin
      req_valid_s = !buf_valid_r || s2_ready;
    end else begin
      req_valid_s = 1'b0;
    end
    req_fire_s   = req_valid_s && mmu_req_ready;
    s2_accept_s  = buf_valid_r && s2_ready;
    // A response is kept only in WAIT and only if no redirect kills it.
    capture_s    = (state_r == ST_WAIT) && mmu_rsp_valid && !redirect_valid;
    rsp_window_s = (state_r == ST_WAIT) || (state_r == ST_DISCARD);
  end

  // Next-state selection for the fetch FSM, including redirect handling.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          // A request accepted alongside a redirect was for the old pc.
          if (req_fire_s) begin
            state_nxt_s = ST_DISCARD;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else if (req_fire_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (mmu_rsp_valid) begin
          // The outstanding request completes now, so a coincident
          // redirect has nothing left to discard.
          if (redirect_valid) begin
            state_nxt_s = ST_FETCH;
          end else if (mmu_rsp_fault) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else if (redirect_valid) begin
          state_nxt_s = ST_DISCARD;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        if (mmu_rsp_valid) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DISCARD;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC and the address of the request currently in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_VECTOR & WORD_MASK;
      inflight_pc_r <= 32'h0000_0000;
    end else begin
      // Redirect wins over the increment: the accepted request is dropped.
      if (redirect_valid) begin
        pc_r <= redirect_pc_s;
      end else if (req_fire_s) begin
        pc_r <= pc_r + PC_STEP;
      end else begin
        pc_r <= pc_r;
      end
      if (req_fire_s) begin
        inflight_pc_r <= pc_r;
      end else begin
        inflight_pc_r <= inflight_pc_r;
      end
    end
  end

  // One-entry s2 buffer: flush on redirect, fill on capture, drain on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_r <= 1'b0;
      buf_instr_r <= 32'h0000_0000;
      buf_pc_r    <= 32'h0000_0000;
      buf_fault_r <= 1'b0;
    end else if (redirect_valid) begin
      buf_valid_r <= 1'b0;
    end else if (capture_s) begin
      buf_valid_r <= 1'b1;
      buf_instr_r <= mmu_rsp_instr;
      buf_pc_r    <= inflight_pc_r;
      buf_fault_r <= mmu_rsp_fault;
    end else if (s2_accept_s) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

  assign mmu_req_valid = req_valid_s;
  assign mmu_req_addr  = pc_r;
  assign s2_valid      = buf_valid_r;
  assign s2_instr      = buf_instr_r;
  assign s2_pc         = buf_pc_r;
  assign s2_fault      = buf_fault_r;

  core_s1_fetch_chk u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .mmu_rsp_valid (mmu_rsp_valid),
    .rsp_window    (rsp_window_s),
    .req_valid     (req_valid_s),
    .req_fire      (req_fire_s),
    .req_addr      (pc_r)
  );

endmodule

// core_s1_fetch_chk: protocol checks for the s1<->MMU fetch interface.
// Responses are only legal while a request is outstanding; responses that
// arrive before the first post-reset request are not checked.
module core_s1_fetch_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        mmu_rsp_valid,
  input logic        rsp_window,
  input logic        req_valid,
  input logic        req_fire,
  input logic [31:0] req_addr
);

  logic armed_r;

  // Arm once the first request after reset has been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r <= 1'b0;
    end else if (req_fire) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

  // Flag stray responses and misaligned request addresses.
  always_ff @(posedge clk) begin
    assert (!(armed_r && mmu_rsp_valid && !rsp_window));
    assert (!(req_valid && (req_addr[1:0] != 2'b00)));
  end

endmodule

// File: tb/tb_core_s1_fetch.sv
// tb_core_s1_fetch: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch stream.

module tb_core_s1_fetch;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mmu_req_valid;
  logic [31:0] mmu_req_addr;
  logic        mmu_req_ready;
  logic        mmu_rsp_valid;
  logic [31:0] mmu_rsp_instr;
  logic        mmu_rsp_fault;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        s2_valid;
  logic        s2_ready;
  logic [31:0] s2_instr;
  logic [31:0] s2_pc;
  logic        s2_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t exp_q[$];

  always #5 clk = ~clk;

  core_s1_fetch #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mmu_req_valid  (mmu_req_valid),
    .mmu_req_addr   (mmu_req_addr),
    .mmu_req_ready  (mmu_req_ready),
    .mmu_rsp_valid  (mmu_rsp_valid),
    .mmu_rsp_instr  (mmu_rsp_instr),
    .mmu_rsp_fault  (mmu_rsp_fault),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .s2_valid       (s2_valid),
    .s2_ready       (s2_ready),
    .s2_instr       (s2_instr),
    .s2_pc          (s2_pc),
    .s2_fault       (s2_fault)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    mmu_req_ready  = 1'b0;
    mmu_rsp_valid  = 1'b0;
    mmu_rsp_instr  = 32'h0;
    mmu_rsp_fault  = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    s2_ready       = 1'b0;
  endtask

  // Leaves the bench in the drive phase of the first FETCH cycle.
  task automatic apply_reset();
    rst_n = 1'b0;
    zero_inputs();
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
  endtask

  // From a FETCH cycle with ready=1: the request fires, then one response.
  task automatic serve(input logic [31:0] a, input logic flt);
    next_cyc();
    mmu_rsp_valid = 1'b1;
    mmu_rsp_instr = instr_of(a);
    mmu_rsp_fault = flt;
    next_cyc();
    mmu_rsp_valid = 1'b0;
    mmu_rsp_fault = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    zero_inputs();
    mid();
    checks++;
    if (mmu_req_valid !== 1'b0 || s2_valid !== 1'b0 || s2_instr !== 32'h0 ||
        s2_pc !== 32'h0 || s2_fault !== 1'b0 || mmu_req_addr !== RV) begin
      failures++;
      $display("FAIL reset_values: req_valid=%b addr=%h s2_valid=%b instr=%h pc=%h fault=%b expected 0,%h,0,0,0,0",
               mmu_req_valid, mmu_req_addr, s2_valid, s2_instr, s2_pc, s2_fault, RV);
    end
    next_cyc();
    rst_n = 1'b1;
    mid();
    checks++;
    if (mmu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: req_valid=%b expected 0", mmu_req_valid);
    end
    next_cyc();
    mid();
    checks++;
    if (mmu_req_valid !== 1'b1 || mmu_req_addr !== RV) begin
      failures++;
      $display("FAIL reset_first_req: valid=%b addr=%h expected 1 %h", mmu_req_valid, mmu_req_addr, RV);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    apply_reset();
    mmu_req_ready = 1'b1;
    s2_ready      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = RV + 32'(4 * k);
      mid();
      checks++;
      if (mmu_req_valid !== 1'b1 || mmu_req_addr !== a) begin
        failures++;
        $display("FAIL stream_req: valid=%b addr=%h expected 1 %h", mmu_req_valid, mmu_req_addr, a);
      end
      if (k > 0) begin
        checks++;
        if (s2_valid !== 1'b1 || s2_pc !== a - 32'd4 || s2_instr !== instr_of(a - 32'd4) || s2_fault !== 1'b0) begin
          failures++;
          $display("FAIL stream_s2: valid=%b pc=%h instr=%h expected 1 %h %h",
                   s2_valid, s2_pc, s2_instr, a - 32'd4, instr_of(a - 32'd4));
        end
      end
      next_cyc();
      mmu_rsp_valid = 1'b1;
      mmu_rsp_instr = instr_of(a);
      mid();
      checks++;
      if (mmu_req_valid !== 1'b0 || s2_valid !== 1'b0) begin
        failures++;
        $display("FAIL stream_wait: req_valid=%b s2_valid=%b expected 0 0", mmu_req_valid, s2_valid);
      end
      next_cyc();
      mmu_rsp_valid = 1'b0;
    end
    mid();
    checks++;
    if (s2_valid !== 1'b1 || s2_pc !== RV + 32'd8 || s2_instr !== instr_of(RV + 32'd8)) begin
      failures++;
      $display("FAIL stream_last: valid=%b pc=%h expected 1 %h", s2_valid, s2_pc, RV + 32'd8);
    end
  endtask

  task automatic test_backpressure_redirect_wait();
    apply_reset();
    mmu_req_ready = 1'b1;
    s2_ready      = 1'b0;
    serve(RV, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mid();
      checks++;
      if (mmu_req_valid !== 1'b0 || s2_valid !== 1'b1 || s2_pc !== RV || s2_instr !== instr_of(RV)) begin
        failures++;
        $display("FAIL hold_buffer: req_valid=%b s2_valid=%b pc=%h expected 0 1 %h",
                 mmu_req_valid, s2_valid, s2_pc, RV);
      end
      next_cyc();
    end
    s2_ready = 1'b1;
    mid();
    checks++;
    if (mmu_req_valid !== 1'b1 || mmu_req_addr !== RV + 32'd4) begin
      failures++;
      $display("FAIL drain_req: valid=%b addr=%h expected 1 %h", mmu_req_valid, mmu_req_addr, RV + 32'd4);
    end
    next_cyc();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_2003;
    mid();
    checks++;
    if (s2_valid !== 1'b0 || mmu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_state: s2_valid=%b req_valid=%b expected 0 0", s2_valid, mmu_req_valid);
    end
    next_cyc();
    redirect_valid = 1'b0;
    mmu_rsp_valid  = 1'b1;
    mmu_rsp_instr  = instr_of(RV + 32'd4);
    mid();
    checks++;
    if (mmu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL discard_noreq: req_valid=%b expected 0", mmu_req_valid);
    end
    next_cyc();
    mmu_rsp_valid = 1'b0;
    mid();
    checks++;
    if (s2_valid !== 1'b0 || mmu_req_valid !== 1'b1 || mmu_req_addr !== 32'h0000_2000) begin
      failures++;
      $display("FAIL redirect_req: s2_valid=%b valid=%b addr=%h expected 0 1 00002000",
               s2_valid, mmu_req_valid, mmu_req_addr);
    end
    serve(32'h0000_2000, 1'b0);
    mid();
    checks++;
    if (s2_valid !== 1'b1 || s2_pc !== 32'h0000_2000 || s2_instr !== instr_of(32'h0000_2000)) begin
      failures++;
      $display("FAIL redirect_s2: valid=%b pc=%h expected 1 00002000", s2_valid, s2_pc);
    end
  endtask

  task automatic test_redirect_on_accept();
    apply_reset();
    mmu_req_ready = 1'b1;
    s2_ready      = 1'b1;
    serve(RV, 1'b0);
    serve(RV + 32'd4, 1'b0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_3000;
    mid();
    checks++;
    if (mmu_req_valid !== 1'b1 || mmu_req_addr !== RV + 32'd8) begin
      failures++;
      $display("FAIL accept_redirect_req: valid=%b addr=%h expected 1 %h", mmu_req_valid, mmu_req_addr, RV + 32'd8);
    end
    next_cyc();
    redirect_valid = 1'b0;
    mmu_rsp_valid  = 1'b1;
    mmu_rsp_instr  = instr_of(RV + 32'd8);
    mid();
    checks++;
    if (mmu_req_valid !== 1'b0 || s2_valid !== 1'b0) begin
      failures++;
      $display("FAIL accept_redirect_discard: req_valid=%b s2_valid=%b expected 0 0", mmu_req_valid, s2_valid);
    end
    next_cyc();
    mmu_rsp_valid = 1'b0;
    mid();
    checks++;
    if (s2_valid !== 1'b0 || mmu_req_valid !== 1'b1 || mmu_req_addr !== 32'h0000_3000) begin
      failures++;
      $display("FAIL accept_redirect_next: s2_valid=%b valid=%b addr=%h expected 0 1 00003000",
               s2_valid, mmu_req_valid, mmu_req_addr);
    end
    serve(32'h0000_3000, 1'b0);
    mid();
    checks++;
    if (s2_valid !== 1'b1 || s2_pc !== 32'h0000_3000) begin
      failures++;
      $display("FAIL accept_redirect_s2: valid=%b pc=%h expected 1 00003000", s2_valid, s2_pc);
    end
  endtask

  task automatic test_fault();
    int reqs;
    apply_reset();
    mmu_req_ready = 1'b1;
    s2_ready      = 1'b1;
    serve(RV, 1'b0);
    serve(RV + 32'd4, 1'b1);
    s2_ready = 1'b0;
    mid();
    checks++;
    if (s2_valid !== 1'b1 || s2_fault !== 1'b1 || s2_pc !== RV + 32'd4) begin
      failures++;
      $display("FAIL fault_entry: valid=%b fault=%b pc=%h expected 1 1 %h", s2_valid, s2_fault, s2_pc, RV + 32'd4);
    end
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      next_cyc();
      if (i == 10) s2_ready = 1'b1;
      mid();
      if (mmu_req_valid === 1'b1) reqs++;
    end
    checks++;
    if (reqs != 0 || s2_valid !== 1'b0) begin
      failures++;
      $display("FAIL fault_halt: requests=%0d s2_valid=%b expected 0 0", reqs, s2_valid);
    end
    next_cyc();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_4000;
    next_cyc();
    redirect_valid = 1'b0;
    mid();
    checks++;
    if (mmu_req_valid !== 1'b1 || mmu_req_addr !== 32'h0000_4000) begin
      failures++;
      $display("FAIL fault_redirect: valid=%b addr=%h expected 1 00004000", mmu_req_valid, mmu_req_addr);
    end
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    mmu_req_ready  = 1'b0;
    s2_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFF;
    next_cyc();
    redirect_valid = 1'b0;
    mmu_req_ready  = 1'b1;
    mid();
    checks++;
    if (mmu_req_valid !== 1'b1 || mmu_req_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_first: valid=%b addr=%h expected 1 fffffffc", mmu_req_valid, mmu_req_addr);
    end
    serve(32'hFFFF_FFFC, 1'b0);
    mid();
    checks++;
    if (mmu_req_valid !== 1'b1 || mmu_req_addr !== 32'h0 || s2_pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_zero: valid=%b addr=%h s2_pc=%h expected 1 00000000 fffffffc",
               mmu_req_valid, mmu_req_addr, s2_pc);
    end
    next_cyc();
    rst_n = 1'b0;
    zero_inputs();
    #1;
    checks++;
    if (mmu_req_valid !== 1'b0 || s2_valid !== 1'b0 || s2_instr !== 32'h0 ||
        s2_pc !== 32'h0 || s2_fault !== 1'b0 || mmu_req_addr !== RV) begin
      failures++;
      $display("FAIL midwait_reset: req_valid=%b addr=%h s2_valid=%b instr=%h pc=%h expected 0 %h 0 0 0",
               mmu_req_valid, mmu_req_addr, s2_valid, s2_instr, s2_pc, RV);
    end
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    mid();
    checks++;
    if (mmu_req_valid !== 1'b1 || mmu_req_addr !== RV) begin
      failures++;
      $display("FAIL post_reset_req: valid=%b addr=%h expected 1 %h", mmu_req_valid, mmu_req_addr, RV);
    end
  endtask

  // Random MMU latency/ready, s2 backpressure, redirects and faults, checked
  // against the expected request-address and delivered-instruction streams.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pend;
    logic        pend_live;
    logic        halted;
    logic        rsp_fire;
    logic        fired;
    logic        acc;
    int          pend_due;
    int          n_acc;
    ent_t        e;
    apply_reset();
    exp_q.delete();
    exp_pc    = RV;
    pend      = 1'b0;
    pend_live = 1'b0;
    pend_addr = 32'h0;
    pend_due  = 0;
    halted    = 1'b0;
    n_acc     = 0;
    for (int c = 0; c < 3000; c++) begin
      mmu_req_ready  = ($urandom_range(0, 9) < 7);
      s2_ready       = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : 32'($urandom);
      rsp_fire       = pend && (c == pend_due);
      mmu_rsp_valid  = rsp_fire;
      mmu_rsp_instr  = instr_of(pend_addr);
      mmu_rsp_fault  = rsp_fire && ($urandom_range(0, 15) == 0);
      mid();
      checks++;
      if (s2_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL rnd_s2_valid: cycle=%0d got %b expected %b", c, s2_valid, exp_q.size() != 0);
      end
      if (s2_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q[0];
        checks++;
        if (s2_pc !== e.pc || s2_fault !== e.fault || (!e.fault && s2_instr !== e.instr)) begin
          failures++;
          $display("FAIL rnd_s2_data: cycle=%0d pc=%h instr=%h fault=%b expected %h %h %b",
                   c, s2_pc, s2_instr, s2_fault, e.pc, e.instr, e.fault);
        end
      end
      if (mmu_req_valid === 1'b1) begin
        checks++;
        if (mmu_req_addr !== exp_pc || halted || pend) begin
          failures++;
          $display("FAIL rnd_req: cycle=%0d addr=%h halted=%b outstanding=%b expected addr %h with none halted/outstanding",
                   c, mmu_req_addr, halted, pend, exp_pc);
        end
      end
      fired = (mmu_req_valid === 1'b1) && mmu_req_ready;
      acc   = (s2_valid === 1'b1) && s2_ready;
      if (acc && !redirect_valid && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_acc++;
      end
      if (rsp_fire) begin
        pend = 1'b0;
        if (pend_live && !redirect_valid) begin
          e.pc    = pend_addr;
          e.instr = mmu_rsp_instr;
          e.fault = mmu_rsp_fault;
          exp_q.push_back(e);
          if (mmu_rsp_fault) halted = 1'b1;
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        halted    = 1'b0;
        pend_live = 1'b0;
        exp_pc    = redirect_addr & 32'hFFFF_FFFC;
      end else if (fired) begin
        exp_pc = exp_pc + 32'd4;
      end
      if (fired) begin
        pend      = 1'b1;
        pend_live = !redirect_valid;
        pend_addr = mmu_req_addr;
        pend_due  = c + int'($urandom_range(1, 3));
      end
      next_cyc();
    end
    zero_inputs();
    checks++;
    if (n_acc <= 100) begin
      failures++;
      $display("FAIL rnd_progress: accepted=%0d expected more than 100", n_acc);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    zero_inputs();
    #1;
    test_reset();
    test_stream();
    test_backpressure_redirect_wait();
    test_redirect_on_accept();
    test_fault();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
